// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan encoder.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_HOLD
  } state_e;

  // Key-code width for n keys, never narrower than one bit.
  function automatic int unsigned code_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row sense lines.
module keypad_row_sync #(
  parameter int unsigned ROWS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [ROWS-1:0] row_i,
  output logic [ROWS-1:0] row_s_o
);

  logic [ROWS-1:0] meta_q;
  logic [ROWS-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_s_o = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// Column-scanning keypad encoder: detect, debounce, report one key event with
// valid/ready handshake, then hold until the key matrix is quiet again.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DEBOUNCE = 16,
  localparam int unsigned CODE_W  = code_width(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   row_i,
  output logic [COLS-1:0]   col_o,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              multi_o,
  output logic              held_o
);

  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned CNT_MAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [COLS-1:0] COL_ONE = {{(COLS-1){1'b0}}, 1'b1};

  logic [ROWS-1:0] row_s;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROWS-1:0]   pat_q, pat_d;
  logic [COLS-1:0]   col_q, col_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              multi_q, multi_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;

  keypad_row_sync #(.ROWS(ROWS)) u_row_sync (
    .clock   (clock),
    .reset   (reset),
    .row_i   (row_i),
    .row_s_o (row_s)
  );

  // Lowest asserted row selects the code; other rows only raise multi.
  function automatic logic [CODE_W-1:0] encode(input logic [ROWS-1:0]  pat,
                                               input logic [COL_W-1:0] idx);
    logic [CODE_W-1:0] low;
    low = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (pat[r]) low = CODE_W'(r);
    end
    return CODE_W'(low * CODE_W'(COLS)) + CODE_W'(idx);
  endfunction

  function automatic logic many(input logic [ROWS-1:0] pat);
    int unsigned n;
    n = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (pat[r]) n++;
    end
    return n > 1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      col_q   <= '1;
      code_q  <= '0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      col_q   <= col_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    code_d  = code_q;
    multi_d = multi_q;

    case (state_q)
      ST_IDLE: begin
        if (row_s != '0) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cnt_q == CNT_W'(SETTLE)) begin
          cnt_d = '0;
          if (row_s != '0) begin
            state_d = ST_DEBOUNCE;
            pat_d   = row_s;
          end else if (idx_q == COL_W'(COLS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + COL_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_s != pat_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          state_d = ST_REPORT;
          cnt_d   = '0;
          code_d  = encode(pat_q, idx_q);
          multi_d = many(pat_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        // Event stays pending regardless of key state until consumed.
        if (ready_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (row_s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    valid_d = (state_d == ST_REPORT);
    held_d  = (state_d == ST_HOLD);
    col_d   = (state_d == ST_IDLE) ? '1 : (COL_ONE << idx_d);
  end

  assign col_o   = col_q;
  assign code_o  = code_q;
  assign multi_o = multi_q;
  assign valid_o = valid_q;
  assign held_o  = held_q;

endmodule
